// File: rtl/axi4lite_reg_slave.sv
// axi4lite_reg_slave
// AXI4-Lite slave front end for a generated register bank. It terminates the
// AW/W/B and AR/R channels, decodes word addresses to register indices and
// drives a single-cycle one-hot write enable with strobe-merged write data
// into the downstream registers. Read data is captured into a register.
//
// Ports
//   clk, reset                    rising-edge clock, synchronous active-high reset
//   s_axi_aw*/w*/b*               AXI4-Lite write address / data / response
//   s_axi_ar*/r*                  AXI4-Lite read address / data
//   reg_wr_en   [NUM_REGS]        one-hot write enable, high for one cycle
//   reg_wr_data [DATA_WIDTH]      byte-merged write data shared by all registers
//   reg_rd_data [NUM_REGS*DW]     current register values, register i at [i*DW +: DW]
//
// Every AXI output is decoded from registered state only, so there is no
// combinational path from an AXI input to an AXI output.

module axi4lite_reg_slave #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                           clk,
    input  logic                           reset,

    input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
    input  logic                           s_axi_awvalid,
    output logic                           s_axi_awready,
    input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
    input  logic                           s_axi_wvalid,
    output logic                           s_axi_wready,
    output logic [1:0]                     s_axi_bresp,
    output logic                           s_axi_bvalid,
    input  logic                           s_axi_bready,

    input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
    input  logic                           s_axi_arvalid,
    output logic                           s_axi_arready,
    output logic [DATA_WIDTH-1:0]          s_axi_rdata,
    output logic [1:0]                     s_axi_rresp,
    output logic                           s_axi_rvalid,
    input  logic                           s_axi_rready,

    output logic [NUM_REGS-1:0]            reg_wr_en,
    output logic [DATA_WIDTH-1:0]          reg_wr_data,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_rd_data
);

    localparam int              IDX_W  = ADDR_WIDTH - 2;
    localparam int              STRB_W = DATA_WIDTH / 8;
    localparam logic [IDX_W:0]  NREGS  = NUM_REGS[IDX_W:0];
    localparam logic [1:0]      RESP_OKAY   = 2'b00;
    localparam logic [1:0]      RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {WR_IDLE, WR_EXEC, WR_RESP} wr_state_t;
    typedef enum logic       {RD_IDLE, RD_RESP}          rd_state_t;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        return {1'b0, idx} < NREGS;
    endfunction

    // Out-of-range indices match no entry and therefore read as zero.
    function automatic logic [DATA_WIDTH-1:0] rd_word(
        input logic [IDX_W-1:0]               idx,
        input logic [NUM_REGS*DATA_WIDTH-1:0] bank
    );
        logic [DATA_WIDTH-1:0] w;
        w = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == IDX_W'(i))
                w = bank[i*DATA_WIDTH +: DATA_WIDTH];
        end
        return w;
    endfunction

    // Address low bits select bytes within a word and carry no meaning here.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // Holds the ready outputs low for the first cycle after reset release.
    logic rst_done;
    always_ff @(posedge clk) begin
        if (reset) rst_done <= 1'b0;
        else       rst_done <= 1'b1;
    end

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    wr_state_t             wr_state, wr_next;
    logic                  aw_held, w_held;
    logic [IDX_W-1:0]      aw_idx;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic                  aw_hs, w_hs, wr_exec;
    logic [DATA_WIDTH-1:0] cur_word;

    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid  && s_axi_wready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) wr_state <= WR_IDLE;
        else       wr_state <= wr_next;
    end

    // Next state: AW and W may land in either order or together.
    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            WR_IDLE: if ((aw_held || aw_hs) && (w_held || w_hs)) wr_next = WR_EXEC;
            WR_EXEC: wr_next = WR_RESP;
            WR_RESP: if (s_axi_bready) wr_next = WR_IDLE;
            default: wr_next = WR_IDLE;
        endcase
    end

    // Outputs decoded from state and held flags
    always_comb begin
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        s_axi_bresp   = RESP_OKAY;
        wr_exec       = 1'b0;
        case (wr_state)
            WR_IDLE: begin
                s_axi_awready = rst_done && !aw_held;
                s_axi_wready  = rst_done && !w_held;
            end
            WR_EXEC: wr_exec = 1'b1;
            WR_RESP: begin
                s_axi_bvalid = 1'b1;
                // aw_idx cannot change until the response is taken.
                s_axi_bresp  = in_range(aw_idx) ? RESP_OKAY : RESP_SLVERR;
            end
            default: ;
        endcase
    end

    // Held address/data
    always_ff @(posedge clk) begin
        if (reset) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            aw_idx  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            if (aw_hs) begin
                aw_held <= 1'b1;
                aw_idx  <= s_axi_awaddr[ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
                w_held  <= 1'b1;
                wdata_q <= s_axi_wdata;
                wstrb_q <= s_axi_wstrb;
            end
            if (wr_exec) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
        end
    end

    always_comb cur_word = rd_word(aw_idx, reg_rd_data);

    // Only in-range indices can match, so an out-of-range write raises nothing.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_wen
        assign reg_wr_en[i] = wr_exec && (aw_idx == IDX_W'(i));
    end

    // Unstrobed bytes keep the register's current contents.
    for (genvar b = 0; b < STRB_W; b++) begin : g_merge
        assign reg_wr_data[b*8 +: 8] = !wr_exec   ? 8'h00 :
                                       wstrb_q[b] ? wdata_q[b*8 +: 8] :
                                                    cur_word[b*8 +: 8];
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    rd_state_t             rd_state, rd_next;
    logic                  ar_hs;
    logic [IDX_W-1:0]      ar_idx;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;

    assign ar_hs  = s_axi_arvalid && s_axi_arready;
    assign ar_idx = s_axi_araddr[ADDR_WIDTH-1:2];

    // State register
    always_ff @(posedge clk) begin
        if (reset) rd_state <= RD_IDLE;
        else       rd_state <= rd_next;
    end

    // Next state
    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            RD_IDLE: if (ar_hs)        rd_next = RD_RESP;
            RD_RESP: if (s_axi_rready) rd_next = RD_IDLE;
            default: rd_next = RD_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        case (rd_state)
            RD_IDLE: s_axi_arready = rst_done;
            RD_RESP: s_axi_rvalid  = 1'b1;
            default: ;
        endcase
    end

    // Captured read data. A capture coinciding with a write's enable cycle
    // sees the pre-write register value, since the bank updates on this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (ar_hs) begin
            rdata_q <= rd_word(ar_idx, reg_rd_data);
            rresp_q <= in_range(ar_idx) ? RESP_OKAY : RESP_SLVERR;
        end
    end

    assign s_axi_rdata = rdata_q;
    assign s_axi_rresp = rresp_q;

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Directed bench for axi4lite_reg_slave with NUM_REGS=4 and a simple
// register bank model behind it.
module tb_axi4lite_reg_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic [3:0]  reg_wr_en;
    logic [31:0] reg_wr_data;
    logic [127:0] reg_rd_data;

    logic [31:0] bank [4];
    int checks = 0, failures = 0;
    int wr_pulses = 0, wen_multi = 0, wen_consec = 0;
    logic [3:0] wen_prev;

    always #5 clk = ~clk;

    axi4lite_reg_slave #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .NUM_REGS(4)) dut (
        .clk(clk), .reset(reset),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .reg_wr_en(reg_wr_en), .reg_wr_data(reg_wr_data), .reg_rd_data(reg_rd_data)
    );

    // Downstream register bank
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (reset)             bank[i] <= 32'h0;
            else if (reg_wr_en[i]) bank[i] <= reg_wr_data;
        end
    end
    assign reg_rd_data = {bank[3], bank[2], bank[1], bank[0]};

    // Write-enable pulse monitor
    always @(posedge clk) begin
        if (reset) wen_prev <= 4'h0;
        else begin
            if (reg_wr_en != 4'h0)                      wr_pulses  <= wr_pulses + 1;
            if ($countones(reg_wr_en) > 1)              wen_multi  <= wen_multi + 1;
            if (reg_wr_en != 4'h0 && wen_prev != 4'h0)  wen_consec <= wen_consec + 1;
            wen_prev <= reg_wr_en;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_zero_outs(input string tag);
        chk({tag, "_ctl"}, 32'({awready, wready, arready, bvalid, rvalid, bresp, rresp, reg_wr_en}), 0);
        chk({tag, "_rdata"}, rdata, 0);
    endtask

    // Called at a negedge with the write side idle.
    task automatic axi_wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] exp_resp, input string tag);
        int n;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while (!(awready && wready) && n < 20) begin @(negedge clk); n++; end
        chk({tag, "_acc"}, 32'(awready && wready), 1);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        n = 0;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        chk({tag, "_b"}, 32'({bvalid, bresp}), 32'({1'b1, exp_resp}));
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic axi_rd(input logic [5:0] a, input logic [31:0] exp_d,
                          input logic [1:0] exp_resp, input string tag);
        int n;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        chk({tag, "_arrdy"}, 32'(arready), 1);
        @(negedge clk);
        arvalid = 1'b0;
        chk({tag, "_r"}, 32'({rvalid, rresp}), 32'({1'b1, exp_resp}));
        chk({tag, "_rdata"}, rdata, exp_d);
        @(negedge clk);
        rready = 1'b0;
    endtask

    initial begin
        int p0;
        reset = 1'b1;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        repeat (3) @(negedge clk);
        chk_zero_outs("rst");
        reset = 1'b0;
        #1 chk_zero_outs("rst_rel");
        @(negedge clk);
        chk("idle_rdy", 32'({awready, wready, arready}), 32'h7);

        // Full write then read, AW and W together
        p0 = wr_pulses;
        awaddr = 6'h08; wdata = 32'hDEADBEEF; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        chk("t1_rdy", 32'(awready && wready), 1);
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        chk("t1_wen", 32'(reg_wr_en), 32'h4);
        chk("t1_wdat", reg_wr_data, 32'hDEADBEEF);
        chk("t1_nob", 32'(bvalid), 0);
        @(negedge clk);
        chk("t1_b", 32'({bvalid, bresp}), 32'h4);
        chk("t1_bank", bank[2], 32'hDEADBEEF);
        bready = 1;
        @(negedge clk);
        bready = 0;
        chk("t1_bdone", 32'(bvalid), 0);
        chk("t1_pulses", 32'(wr_pulses - p0), 1);
        axi_rd(6'h08, 32'hDEADBEEF, 2'b00, "t1_rd");

        // Byte strobe merge
        axi_wr(6'h04, 32'h11223344, 4'hF, 2'b00, "t2_pre");
        awaddr = 6'h04; wdata = 32'hAABBCCDD; wstrb = 4'h5; awvalid = 1; wvalid = 1;
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        chk("t2_wen", 32'(reg_wr_en), 32'h2);
        chk("t2_merge", reg_wr_data, 32'h11BB33DD);
        bready = 1;
        @(negedge clk);
        chk("t2_b", 32'({bvalid, bresp}), 32'h4);
        @(negedge clk);
        bready = 0;
        axi_rd(6'h04, 32'h11BB33DD, 2'b00, "t2_rd");

        // Skewed channels, W three cycles ahead of AW, B backpressure
        p0 = wr_pulses;
        wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1;
        chk("t3_wrdy", 32'(wready), 1);
        @(negedge clk);
        wvalid = 0;
        chk("t3_wdrop", 32'({wready, awready}), 32'h1);
        repeat (2) @(negedge clk);
        chk("t3_nowen", 32'(wr_pulses - p0), 0);
        awaddr = 6'h0C; awvalid = 1;
        @(negedge clk);
        awvalid = 0;
        chk("t3_wen", 32'(reg_wr_en), 32'h8);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("t3_bhold%0d", k), 32'({bvalid, bresp, reg_wr_en}), 32'h40);
        end
        bready = 1;
        @(negedge clk);
        bready = 0;
        chk("t3_bdone", 32'(bvalid), 0);
        chk("t3_pulses", 32'(wr_pulses - p0), 1);
        axi_rd(6'h0C, 32'h12345678, 2'b00, "t3_rd");

        // Out of range
        p0 = wr_pulses;
        axi_wr(6'h10, 32'hFFFFFFFF, 4'hF, 2'b10, "t4_wr");
        chk("t4_nowen", 32'(wr_pulses - p0), 0);
        axi_rd(6'h3C, 32'h0, 2'b10, "t4_rd");

        // Concurrent read in the write's enable cycle
        axi_wr(6'h08, 32'h0, 4'hF, 2'b00, "t5_pre");
        awaddr = 6'h08; wdata = 32'h5; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        chk("t5_exec", 32'({reg_wr_en, arready}), 32'h9);
        araddr = 6'h08; arvalid = 1; bready = 1;
        @(negedge clk);
        arvalid = 0; rready = 1;
        chk("t5_rv", 32'({rvalid, bvalid}), 32'h3);
        chk("t5_old", rdata, 32'h0);
        @(negedge clk);
        rready = 0; bready = 0;
        axi_rd(6'h08, 32'h5, 2'b00, "t5_new");

        // Reset mid-transaction
        p0 = wr_pulses;
        awaddr = 6'h04; awvalid = 1;
        @(negedge clk);
        awvalid = 0; reset = 1;
        @(negedge clk);
        chk_zero_outs("t6_rst");
        reset = 0;
        #1 chk_zero_outs("t6_rel");
        @(negedge clk);
        chk("t6_rdy", 32'({awready, wready}), 32'h3);
        wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1;
        @(negedge clk);
        wvalid = 0;
        repeat (5) @(negedge clk);
        chk("t6_idle", 32'({bvalid, awready, wready}), 32'h2);
        chk("t6_nowen", 32'(wr_pulses - p0), 0);
        awaddr = 6'h04; awvalid = 1;
        @(negedge clk);
        awvalid = 0;
        chk("t6_wen", 32'(reg_wr_en), 32'h2);
        chk("t6_wdat", reg_wr_data, 32'hCAFEF00D);
        bready = 1;
        @(negedge clk);
        chk("t6_b", 32'({bvalid, bresp}), 32'h4);
        @(negedge clk);
        bready = 0;
        axi_rd(6'h04, 32'hCAFEF00D, 2'b00, "t6_rd");

        chk("wen_multi", 32'(wen_multi), 0);
        chk("wen_consec", 32'(wen_consec), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
